apb4_slave_ctrl: RTL
====================

APB4_SLAVE_CTRL -- requirements
Module: apb4_slave_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values are 8, 16 and 32.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, fixed wait states inserted before PREADY is allowed.
REQ-004 SHALL have parameter ADDR_LIMIT, default 'h040, first unmapped byte address.
REQ-005 SHALL have parameter PROT_CHECK, default 0; when 1, writes with tim_pprot[0]=0 are rejected.
REQ-006 SHALL have ports, in this order:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- tim_psel  in  1  APB select.
- tim_penable  in  1  APB enable.
- tim_pwrite  in  1  1 = write.
- tim_paddr  in  ADDR_W  byte address.
- tim_pwdata  in  DATA_W  write data.
- tim_pstrb  in  DATA_W/8  byte strobes.
- tim_pprot  in  3  protection.
- tim_prdata  out  DATA_W  read data.
- tim_pready  out  1  transfer complete.
- tim_pslverr  out  1  transfer error.
- reg_addr  out  ADDR_W  latched address.
- reg_wdata  out  DATA_W  latched write data.
- reg_strb  out  DATA_W/8  latched strobes.
- wr_en  out  1  one-cycle write pulse.
- rd_en  out  1  one-cycle read pulse.
- reg_rdata  in  DATA_W  register read data.
- reg_busy  in  1  register file stall request.
- reg_error_flag  in  1  register-side error.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT and ACCESS.
REQ-008 SHALL, in IDLE on tim_psel=1 and tim_penable=0 (setup phase), latch tim_paddr, tim_pwdata, tim_pstrb, tim_pwrite and the decode error, then go to WAIT if WAIT_CYCLES>0, else to ACCESS.
REQ-009 SHALL ignore tim_penable=1 while in IDLE (no setup seen): no state change and no strobes.
REQ-010 SHALL, in WAIT, load the counter with WAIT_CYCLES-1 on entry, decrement it every cycle, and go to ACCESS when it reaches 0; WAIT therefore lasts exactly WAIT_CYCLES cycles.
REQ-011 SHALL drive tim_pready = (state==ACCESS) & tim_psel & tim_penable & !reg_busy; ACCESS SHALL hold while reg_busy=1.
REQ-012 SHALL return from ACCESS to IDLE in the cycle after tim_pready=1, so back-to-back transfers need no dead cycle beyond the APB setup phase.
REQ-013 SHALL, if tim_psel=0 in WAIT or ACCESS (abort), go to IDLE with no wr_en, rd_en or tim_pslverr.
REQ-014 SHALL set the latched decode error when any of these hold:
- reg_addr >= ADDR_LIMIT;
- reg_addr low log2(DATA_W/8) bits are nonzero;
- a read has a nonzero tim_pstrb;
- PROT_CHECK=1 and a write has tim_pprot[0]=0.
REQ-015 SHALL drive tim_pslverr = tim_pready & (decode error | reg_error_flag), with reg_error_flag sampled live.
REQ-016 SHALL drive wr_en = tim_pready & write & !decode error & (reg_strb != 0); a write with zero strobes completes OKAY with no wr_en.
REQ-017 SHALL drive rd_en = tim_pready & !write & !decode error.
REQ-018 SHALL drive tim_prdata = reg_rdata when rd_en=1, else all zeros.
REQ-019 SHALL hold reg_addr, reg_wdata and reg_strb stable from the cycle after setup until the next setup.
REQ-020 SHALL size the wait counter as $clog2(WAIT_CYCLES+1) bits, minimum 1, with no wrap.

Reset
REQ-021 SHALL, on sys_rst_n=0, asynchronously force state=IDLE, counter=0, latched fields=0 and decode error=0.
REQ-022 SHALL hold tim_pready, tim_pslverr, wr_en and rd_en at 0 and tim_prdata at 0 while reset is asserted.
REQ-023 SHALL, on reset mid-transfer, drop the transfer with no pulse after release; the next setup phase is handled normally.

Structure
REQ-024 SHALL place the FSM state encoding (IDLE=2'b00, WAIT=2'b01, ACCESS=2'b10) and the decode-error cause constants in shared package apb_pkg.
REQ-025 SHALL implement the wait-state down-counter as sub-module apb_wait_counter (load, dec, zero flag); all other logic stays in apb4_slave_ctrl.

Verification
REQ-026 SHALL cover: WAIT_CYCLES=0, write 0xDEADBEEF to 0x004 with strb 0xF -> tim_pready and wr_en at the 2nd cycle, reg_addr=0x004, tim_pslverr=0.
REQ-027 SHALL cover: WAIT_CYCLES=3, read 0x008, reg_rdata=0x12345678 -> tim_pready in the 5th cycle after setup, rd_en one cycle, tim_prdata=0x12345678.
REQ-028 SHALL cover: writes to 0x040 (unmapped) and 0x006 (misaligned) -> tim_pslverr=1 with tim_pready, wr_en=0.
REQ-029 SHALL cover: reg_busy high for 4 cycles in ACCESS -> tim_pready delayed 4 cycles; a single wr_en pulse.
REQ-030 SHALL cover: tim_psel dropped in WAIT -> FSM back in IDLE next cycle, no strobes; reset asserted in ACCESS -> all outputs 0 immediately.
REQ-031 SHALL cover: PROT_CHECK=1, write with tim_pprot=3'b000 -> tim_pslverr=1, wr_en=0; a read with tim_pstrb=0x1 -> tim_pslverr=1, rd_en=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 slave controller: FSM encoding,
// decode-error cause indices and wait-counter sizing.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  // Bit positions inside the decode-error cause vector.
  localparam int unsigned ERR_RANGE   = 0;  // address at or beyond ADDR_LIMIT
  localparam int unsigned ERR_ALIGN   = 1;  // address not word aligned
  localparam int unsigned ERR_RD_STRB = 2;  // read issued with nonzero strobes
  localparam int unsigned ERR_PROT    = 3;  // unprivileged write when protected
  localparam int unsigned ERR_CAUSE_W = 4;

  // Wait counter width: enough to hold WAIT_CYCLES, never below one bit.
  function automatic int unsigned wait_cnt_width(input int unsigned cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Saturating down-counter timing the fixed wait states of a transfer.
module apb_wait_counter #(
  parameter int unsigned            WIDTH    = 1,
  parameter logic [WIDTH-1:0]       LOAD_VAL = '0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load wins, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb4_slave_ctrl.sv
// APB4 slave front end: latches each setup phase, inserts fixed wait
// states, honours register-file stalls and turns completed transfers into
// single-cycle wr_en / rd_en pulses with decode-error reporting.
module apb4_slave_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_LIMIT  = 'h040,
  parameter int unsigned PROT_CHECK  = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                tim_psel,
  input  logic                tim_penable,
  input  logic                tim_pwrite,
  input  logic [ADDR_W-1:0]   tim_paddr,
  input  logic [DATA_W-1:0]   tim_pwdata,
  input  logic [DATA_W/8-1:0] tim_pstrb,
  input  logic [2:0]          tim_pprot,
  output logic [DATA_W-1:0]   tim_prdata,
  output logic                tim_pready,
  output logic                tim_pslverr,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [DATA_W/8-1:0] reg_strb,
  output logic                wr_en,
  output logic                rd_en,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic                reg_busy,
  input  logic                reg_error_flag
);

  localparam int unsigned       STRB_W     = DATA_W / 8;
  localparam int unsigned       ALIGN_BITS = $clog2(STRB_W);
  localparam int unsigned       CNT_W      = wait_cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD   = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [ADDR_W:0]   LIMIT      = (ADDR_W + 1)'(ADDR_LIMIT);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN_BITS) - 1);

  apb_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]       reg_wdata_q, reg_wdata_d;
  logic [STRB_W-1:0]       reg_strb_q, reg_strb_d;
  logic                    write_q, write_d;
  logic                    dec_err_q, dec_err_d;
  logic [ERR_CAUSE_W-1:0]  err_cause;
  logic                    cnt_load, cnt_dec, cnt_zero;
  logic                    ready;
  logic                    unused_prot;

  // Only the privileged bit of PPROT takes part in access control.
  assign unused_prot = ^tim_pprot[2:1];

  apb_wait_counter #(
    .WIDTH    (CNT_W),
    .LOAD_VAL (CNT_LOAD)
  ) u_wait_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (cnt_load),
    .dec       (cnt_dec),
    .zero      (cnt_zero)
  );

  // Decode-error causes evaluated on the live setup-phase bus.
  always_comb begin
    err_cause              = '0;
    err_cause[ERR_RANGE]   = ({1'b0, tim_paddr} >= LIMIT);
    err_cause[ERR_ALIGN]   = ((tim_paddr & ALIGN_MASK) != '0);
    err_cause[ERR_RD_STRB] = !tim_pwrite && (tim_pstrb != '0);
    err_cause[ERR_PROT]    = (PROT_CHECK != 0) && tim_pwrite && !tim_pprot[0];
  end

  assign ready = (state_q == ACCESS) && tim_psel && tim_penable && !reg_busy;

  // Next-state, setup-phase capture and wait-counter control.
  always_comb begin
    state_d     = state_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_strb_d  = reg_strb_q;
    write_d     = write_q;
    dec_err_d   = dec_err_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tim_psel && !tim_penable) begin
          reg_addr_d  = tim_paddr;
          reg_wdata_d = tim_pwdata;
          reg_strb_d  = tim_pstrb;
          write_d     = tim_pwrite;
          dec_err_d   = |err_cause;
          if (WAIT_CYCLES > 0) begin
            state_d  = WAIT;
            cnt_load = 1'b1;
          end else begin
            state_d  = ACCESS;
          end
        end
      end
      WAIT: begin
        if (!tim_psel) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d = ACCESS;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ACCESS: begin
        if (!tim_psel || ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched transfer fields.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_strb_q  <= '0;
      write_q     <= 1'b0;
      dec_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_strb_q  <= reg_strb_d;
      write_q     <= write_d;
      dec_err_q   <= dec_err_d;
    end
  end

  assign tim_pready  = ready;
  assign tim_pslverr = ready && (dec_err_q || reg_error_flag);
  assign wr_en       = ready && write_q && !dec_err_q && (reg_strb_q != '0);
  assign rd_en       = ready && !write_q && !dec_err_q;
  assign tim_prdata  = rd_en ? reg_rdata : '0;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_strb    = reg_strb_q;

endmodule
